// File: rtl/pkt_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// pkt_dispatch_pkg
// Shared definitions for the packet dispatch sequencer:
//   - packet type codes carried in the 3-bit header type field
//   - header layout as stored in the dispatch FIFO
//   - dispatcher FSM state encoding
// -----------------------------------------------------------------------------
package pkt_dispatch_pkg;

    // Packet type codes
    localparam logic [2:0] PKT_HB      = 3'b000;
    localparam logic [2:0] PKT_CHE     = 3'b001;
    localparam logic [2:0] PKT_INV     = 3'b010;
    localparam logic [2:0] PKT_MR      = 3'b011;
    localparam logic [2:0] PKT_CHT     = 3'b100;
    localparam logic [2:0] PKT_DATA    = 3'b101;
    localparam logic [2:0] PKT_SOS     = 3'b110;
    localparam logic [2:0] PKT_INVALID = 3'b111;

    // Stored header: {type, destination ID}
    typedef struct packed {
        logic [2:0]  ptype;
        logic [15:0] dest;
    } hdr_t;

    localparam int HDR_W = $bits(hdr_t);

    // Dispatcher FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

    // Headers of this type are consumed without ever reaching the filter.
    function automatic logic is_dropped(input logic [2:0] ptype);
        return ptype == PKT_INVALID;
    endfunction

endpackage

// File: rtl/pkt_dispatch_fifo.sv
// -----------------------------------------------------------------------------
// pkt_dispatch_fifo
// Synchronous single-clock FIFO with first-word fall-through read data.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
//
// Ports:
//   clk      in   clock, rising edge
//   nrst     in   asynchronous active-low reset (pointers/count only)
//   push_i   in   write wdata_i (ignored when full)
//   wdata_i  in   write data
//   pop_i    in   discard head entry (ignored when empty)
//   rdata_o  out  head entry, valid while empty_o is 0
//   empty_o  out  no entries stored
//   count_o  out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module pkt_dispatch_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: storage has no reset; entries are only read after being written,
    // and leaving it out lets the array map onto plain flops/RAM cells.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pkt_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// pkt_dispatch_ctrl
// Buffers decoded packet headers and hands them to packetFilter one at a
// time. Each dispatched header produces a single-cycle flt_newpkt strobe; the
// next header is held back until the downstream block signals blk_done, so
// enables of consecutive packets never overlap. Type 3'b111 headers are
// dropped in IDLE without a strobe.
//
// Build option:
//   PKT_DISPATCH_TIMEOUT_EN  adds a WAIT watchdog of TIMEOUT_CYCLES and the
//                            timeout_err output port.
//
// Ports:
//   clk           in   clock, rising edge
//   nrst          in   asynchronous active-low reset
//   pkt_valid     in   receive header available
//   pkt_type      in   header type field
//   pkt_dest      in   header destination ID
//   pkt_ready     out  FIFO not full (header accepted on valid && ready)
//   flt_newpkt    out  one-cycle strobe to packetFilter.newpkt
//   flt_pkt_type  out  type presented to the filter, held until next pop
//   flt_dest_id   out  destination presented to the filter, held until next pop
//   blk_done      in   downstream block finished the current packet
//   busy          out  FSM not in IDLE (registered)
//   dispatch_cnt  out  completed packets, saturating
//   drop_cnt      out  dropped type-7 packets, saturating
//   timeout_err   out  watchdog expiry pulse (timeout build only)
// -----------------------------------------------------------------------------
`default_nettype none

module pkt_dispatch_ctrl
    import pkt_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic        clk,
    input  wire logic        nrst,
    input  wire logic        pkt_valid,
    input  wire logic [2:0]  pkt_type,
    input  wire logic [15:0] pkt_dest,
    output logic             pkt_ready,
    output logic             flt_newpkt,
    output logic [2:0]       flt_pkt_type,
    output logic [15:0]      flt_dest_id,
    input  wire logic        blk_done,
    output logic             busy,
    output logic [15:0]      dispatch_cnt,
    output logic [7:0]       drop_cnt
`ifdef PKT_DISPATCH_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Header queue
    // ------------------------------------------------------------------
    logic [HDR_W-1:0] fifo_rdata;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_pop;
    hdr_t             head;

    pkt_dispatch_fifo #(
        .WIDTH (HDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push_i  (pkt_valid),
        .wdata_i ({pkt_type, pkt_dest}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head      = hdr_t'(fifo_rdata);
    assign pkt_ready = (fifo_count != CNT_W'(FIFO_DEPTH));

    // ------------------------------------------------------------------
    // FSM and output registers
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic        newpkt_q, newpkt_d;
    logic [2:0]  flt_type_q, flt_type_d;
    logic [15:0] flt_dest_q, flt_dest_d;
    logic        busy_q, busy_d;
    logic [15:0] dispatch_cnt_q, dispatch_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        tmo_expire;

`ifdef PKT_DISPATCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;

    // Counter holds the number of WAIT edges already survived; the edge
    // that would make it TIMEOUT_CYCLES is the expiry edge.
    assign tmo_expire = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_expire = 1'b0;
`endif

    // NOTE: every variable assigned here gets a default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d        = state_q;
        newpkt_d       = newpkt_q;
        flt_type_d     = flt_type_q;
        flt_dest_d     = flt_dest_q;
        dispatch_cnt_d = dispatch_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        fifo_pop       = 1'b0;
`ifdef PKT_DISPATCH_TIMEOUT_EN
        tmo_cnt_d      = tmo_cnt_q;
        tmo_err_d      = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    flt_type_d = head.ptype;
                    flt_dest_d = head.dest;
                    if (is_dropped(head.ptype)) begin
                        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                    end else begin
                        newpkt_d = 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end
            end

            // blk_done is deliberately ignored here: it may still belong to
            // the previous packet's block.
            ST_ISSUE: begin
                newpkt_d = 1'b0;
                state_d  = ST_WAIT;
`ifdef PKT_DISPATCH_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end

            ST_WAIT: begin
                if (blk_done) begin
                    // Completion takes priority over a coincident expiry.
                    if (dispatch_cnt_q != 16'hFFFF) begin
                        dispatch_cnt_d = dispatch_cnt_q + 16'd1;
                    end
                    state_d = ST_IDLE;
                end else if (tmo_expire) begin
`ifdef PKT_DISPATCH_TIMEOUT_EN
                    tmo_err_d = 1'b1;
`endif
                    state_d = ST_IDLE;
                end else begin
`ifdef PKT_DISPATCH_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
                end
            end

            default: begin
                newpkt_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= ST_IDLE;
            newpkt_q       <= 1'b0;
            flt_type_q     <= 3'b000;
            flt_dest_q     <= 16'h0000;
            busy_q         <= 1'b0;
            dispatch_cnt_q <= 16'h0000;
            drop_cnt_q     <= 8'h00;
        end else begin
            state_q        <= state_d;
            newpkt_q       <= newpkt_d;
            flt_type_q     <= flt_type_d;
            flt_dest_q     <= flt_dest_d;
            busy_q         <= busy_d;
            dispatch_cnt_q <= dispatch_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

`ifdef PKT_DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`endif

    assign flt_newpkt   = newpkt_q;
    assign flt_pkt_type = flt_type_q;
    assign flt_dest_id  = flt_dest_q;
    assign busy         = busy_q;
    assign dispatch_cnt = dispatch_cnt_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

`default_nettype wire
